// File: rtl/udp_tx_sequencer_if.sv
`timescale 1ns/1ps
// udp_tx_sequencer_if: request, header fetch, payload and wire-byte
// signals between the UDP transmit sequencer and its neighbours.
interface udp_tx_sequencer_if;
  logic        phy_ready;
  logic        send_req;
  logic [10:0] send_len;
  logic        send_ack;
  logic        send_err;
  logic        busy;
  logic [1:0]  hdr_sel;
  logic [4:0]  hdr_idx;
  logic [7:0]  hdr_byte;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_err;
  logic        frame_done;

  modport master (
    input  phy_ready,
    input  send_req,
    input  send_len,
    input  hdr_byte,
    input  pl_data,
    input  pl_valid,
    output send_ack,
    output send_err,
    output busy,
    output hdr_sel,
    output hdr_idx,
    output pl_ready,
    output tx_data,
    output tx_valid,
    output tx_err,
    output frame_done
  );

  modport slave (
    output phy_ready,
    output send_req,
    output send_len,
    output hdr_byte,
    output pl_data,
    output pl_valid,
    input  send_ack,
    input  send_err,
    input  busy,
    input  hdr_sel,
    input  hdr_idx,
    input  pl_ready,
    input  tx_data,
    input  tx_valid,
    input  tx_err,
    input  frame_done
  );
endinterface

// File: rtl/udp_tx_sequencer.sv
`timescale 1ns/1ps
// udp_tx_sequencer: frame scheduler for the UDP transmit byte stream.
// Preamble/SFD, header fetch, payload, pad, CRC-32 FCS and IFG.
module udp_tx_sequencer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12,
  parameter int MIN_PAYLOAD  = 18,
  parameter int MAX_PAYLOAD  = 1472
) (
  input logic                clk,
  input logic                rst,
  udp_tx_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    SFD,
    ETH,
    IP,
    UDP,
    PAY,
    PAD,
    FCS,
    ABORT,
    IFG
  } state_t;

  localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
  localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);
  localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
  localparam logic [31:0] POLY     = 32'hEDB8_8320;

  state_t      state, state_n;
  logic [10:0] cnt, cnt_n;
  logic [10:0] rem, rem_n;
  logic [10:0] len, len_n;
  logic [31:0] crc, crc_n;
  logic [31:0] fcs;
  logic [10:0] hdr_last;
  logic [10:0] pad_last;
  logic        len_ok;

  logic [7:0]  data_n;
  logic        valid_n;
  logic        err_n;
  logic        done_n;
  logic        ack_n;
  logic        serr_n;
  logic        busy_n;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  assign fcs      = ~crc;
  assign pad_last = MIN_LEN - len - 11'd1;
  assign len_ok   = (bus.send_len != 11'd0) &&
                    (bus.send_len <= MAX_LEN);

  assign hdr_last = (state == ETH) ? 11'd13 :
                    (state == IP)  ? 11'd19 : 11'd7;

  assign bus.pl_ready = (state == PAY) && (rem != 11'd0);

  always_comb begin
    bus.hdr_sel = 2'd0;
    bus.hdr_idx = 5'd0;
    unique case (state)
      ETH: bus.hdr_idx = cnt[4:0];
      IP: begin
        bus.hdr_sel = 2'd1;
        bus.hdr_idx = cnt[4:0];
      end
      UDP: begin
        bus.hdr_sel = 2'd2;
        bus.hdr_idx = cnt[4:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    len_n   = len;
    crc_n   = crc;
    data_n  = 8'h00;
    valid_n = 1'b0;
    err_n   = 1'b0;
    done_n  = 1'b0;
    ack_n   = 1'b0;
    serr_n  = 1'b0;
    busy_n  = bus.busy;
    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        cnt_n  = '0;
        if (bus.send_req && bus.phy_ready) begin
          if (len_ok) begin
            ack_n   = 1'b1;
            busy_n  = 1'b1;
            len_n   = bus.send_len;
            rem_n   = bus.send_len;
            state_n = PRE;
          end else begin
            serr_n = 1'b1;
          end
        end
      end
      PRE: begin
        valid_n = 1'b1;
        data_n  = 8'h55;
        if (cnt == PRE_LAST) begin
          cnt_n   = '0;
          state_n = SFD;
        end else begin
          cnt_n = cnt + 11'd1;
        end
      end
      SFD: begin
        valid_n = 1'b1;
        data_n  = 8'hD5;
        cnt_n   = '0;
        state_n = ETH;
      end
      ETH, IP, UDP: begin
        valid_n = 1'b1;
        data_n  = bus.hdr_byte;
        crc_n   = crc_byte(crc, bus.hdr_byte);
        if (cnt == hdr_last) begin
          cnt_n   = '0;
          state_n = (state == ETH) ? IP :
                    ((state == IP) ? UDP : PAY);
        end else begin
          cnt_n = cnt + 11'd1;
        end
      end
      PAY: begin
        valid_n = 1'b1;
        if (bus.pl_valid) begin
          data_n = bus.pl_data;
          crc_n  = crc_byte(crc, bus.pl_data);
          rem_n  = rem - 11'd1;
          if (rem == 11'd1) begin
            cnt_n   = '0;
            state_n = (len < MIN_LEN) ? PAD : FCS;
          end
        end else begin
          // underrun: the abort marker takes this slot
          err_n   = 1'b1;
          done_n  = 1'b1;
          state_n = ABORT;
        end
      end
      PAD: begin
        valid_n = 1'b1;
        crc_n   = crc_byte(crc, 8'h00);
        if (cnt == pad_last) begin
          cnt_n   = '0;
          state_n = FCS;
        end else begin
          cnt_n = cnt + 11'd1;
        end
      end
      FCS: begin
        valid_n = 1'b1;
        data_n  = fcs[{cnt[1:0], 3'b000} +: 8];
        if (cnt[1:0] == 2'd3) begin
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = IFG;
        end else begin
          cnt_n = cnt + 11'd1;
        end
      end
      ABORT: begin
        // marker cycle already occupies the first gap slot
        cnt_n   = 11'd1;
        state_n = IFG;
      end
      IFG: begin
        if (cnt >= IFG_LAST) begin
          cnt_n   = '0;
          crc_n   = 32'hFFFF_FFFF;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 11'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      rem            <= '0;
      len            <= '0;
      crc            <= 32'hFFFF_FFFF;
      bus.tx_data    <= '0;
      bus.tx_valid   <= 1'b0;
      bus.tx_err     <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.send_ack   <= 1'b0;
      bus.send_err   <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      rem            <= rem_n;
      len            <= len_n;
      crc            <= crc_n;
      bus.tx_data    <= data_n;
      bus.tx_valid   <= valid_n;
      bus.tx_err     <= err_n;
      bus.frame_done <= done_n;
      bus.send_ack   <= ack_n;
      bus.send_err   <= serr_n;
      bus.busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_udp_tx_sequencer.sv
`timescale 1ns/1ps
// tb_udp_tx_sequencer: directed and randomized frames compared
// against a byte-list model of the expected wire stream.
module tb_udp_tx_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0]  hdr_tab [0:3][0:31];
  logic [7:0]  pl_mem  [0:2047];
  logic [31:0] crc_tab [0:255];
  logic [8:0]  exp_q [$];
  logic [8:0]  got_q [$];
  logic [7:0]  body_q [$];
  int          pl_ptr;
  int          drop_at = -1;
  logic        pl_clr = 1'b1;

  udp_tx_sequencer_if bus ();

  udp_tx_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #4 clk = ~clk;

  assign bus.hdr_byte = hdr_tab[bus.hdr_sel][bus.hdr_idx];
  assign bus.pl_data  = pl_mem[pl_ptr[10:0]];
  assign bus.pl_valid = (pl_ptr != drop_at);

  always @(posedge clk)
    if (pl_clr) pl_ptr <= 0;
    else if (bus.pl_valid && bus.pl_ready) pl_ptr <= pl_ptr + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_tables();
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 32; i++)
        hdr_tab[s][i] = 8'($urandom);
    for (int i = 0; i < 2048; i++)
      pl_mem[i] = 8'($urandom);
  endtask

  // Wire image: preamble, SFD, 42 header bytes, payload, pad, FCS.
  task automatic build_exp(input int len, input int drop);
    logic [31:0] c;
    int n;
    exp_q = {};
    body_q = {};
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    for (int i = 0; i < 14; i++) body_q.push_back(hdr_tab[0][i]);
    for (int i = 0; i < 20; i++) body_q.push_back(hdr_tab[1][i]);
    for (int i = 0; i < 8; i++) body_q.push_back(hdr_tab[2][i]);
    n = (drop >= 0 && drop < len) ? drop : len;
    for (int i = 0; i < n; i++) body_q.push_back(pl_mem[i]);
    if (n < len) begin
      foreach (body_q[i]) exp_q.push_back({1'b0, body_q[i]});
      exp_q.push_back(9'h100);
      return;
    end
    for (int i = len; i < 18; i++) body_q.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (body_q[i])
      c = crc_tab[8'(c ^ {24'h0, body_q[i]})] ^ (c >> 8);
    c = ~c;
    foreach (body_q[i]) exp_q.push_back({1'b0, body_q[i]});
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 8'(c >> (8 * k))});
  endtask

  task automatic run_frame(input int len, input int drop,
                           input bit hold, input bit phy_drop);
    int waited, gaps, hdr_bad, pr_cnt, done_seen, stray, idle, n;
    int pos, esel, eidx, nb;
    logic [1:0] psel;
    logic [4:0] pidx;
    build_exp(len, drop);
    n = (drop >= 0 && drop < len) ? drop : len;
    drop_at = drop;
    pl_clr = 1'b1;
    @(negedge clk);
    pl_clr = 1'b0;
    bus.send_len = 11'(len);
    bus.send_req = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.send_ack && waited < 50);
    check("accept", 32'(bus.send_ack), 1);
    check("first_lat", 32'(bus.tx_valid), 0);
    if (!hold) bus.send_req = 1'b0;
    if (phy_drop) bus.phy_ready = 1'b0;
    got_q = {};
    gaps = 0; hdr_bad = 0; pr_cnt = 0; done_seen = 0; stray = 0;
    psel = bus.hdr_sel;
    pidx = bus.hdr_idx;
    for (int cyc = 0; cyc < 4000 && done_seen == 0; cyc++) begin
      @(negedge clk);
      if (bus.pl_ready) pr_cnt++;
      if (bus.send_ack || bus.send_err) stray++;
      if (bus.tx_valid) begin
        pos = got_q.size();
        if (pos >= 8 && pos < 50) begin
          esel = (pos < 22) ? 0 : (pos < 42) ? 1 : 2;
          eidx = pos - ((pos < 22) ? 8 : (pos < 42) ? 22 : 42);
          if (32'(psel) != esel || 32'(pidx) != eidx) hdr_bad++;
        end
        got_q.push_back({bus.tx_err, bus.tx_data});
        if (bus.frame_done) done_seen = 1;
      end else begin
        if (got_q.size() > 0) gaps++;
        if (bus.frame_done) stray++;
      end
      psel = bus.hdr_sel;
      pidx = bus.hdr_idx;
    end
    check("frame_done", 32'(done_seen), 1);
    check("length", 32'(got_q.size()), 32'(exp_q.size()));
    nb = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nb; i++)
      check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("no_gap", 32'(gaps), 0);
    check("hdr_sel_idx", 32'(hdr_bad), 0);
    check("stray_pulse", 32'(stray), 0);
    check("pl_ready_cycles", 32'(pr_cnt), 32'((n < len) ? n + 1 : len));
    check("consumed", 32'(pl_ptr), 32'(n));
    if (!hold) begin
      idle = 0;
      stray = 0;
      while (idle < 40) begin
        @(negedge clk);
        if (!bus.busy) break;
        idle++;
        if (bus.tx_valid) stray++;
      end
      check("ifg_busy_cycles", 32'(idle), 12);
      check("ifg_quiet", 32'(stray), 0);
    end
    bus.phy_ready = 1'b1;
  endtask

  task automatic reject(input int len);
    @(negedge clk);
    bus.send_len = 11'(len);
    bus.send_req = 1'b1;
    @(negedge clk);
    check($sformatf("rej%0d_err", len), 32'(bus.send_err), 1);
    check($sformatf("rej%0d_ack", len), 32'(bus.send_ack), 0);
    bus.send_req = 1'b0;
    @(negedge clk);
    check($sformatf("rej%0d_idle", len),
          32'({bus.tx_valid, bus.busy, bus.send_err}), 0);
  endtask

  initial begin
    logic [31:0] r;
    int cnt, bad, len, drop;
    for (int i = 0; i < 256; i++) begin
      r = 32'(i);
      for (int k = 0; k < 8; k++)
        r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      crc_tab[i] = r;
    end
    rand_tables();
    bus.phy_ready = 1'b1;
    bus.send_req  = 1'b1;
    bus.send_len  = 11'd18;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({bus.tx_data, bus.tx_valid, bus.tx_err, bus.pl_ready,
               bus.busy, bus.send_ack, bus.send_err, bus.frame_done,
               bus.hdr_sel, bus.hdr_idx}), 0);
    rst = 1'b1;
    pl_clr = 1'b0;
    @(negedge clk);
    check("rst_release_ack", 32'(bus.send_ack), 1);
    check("rst_release_txv", 32'(bus.tx_valid), 0);
    bus.send_req = 1'b0;
    @(negedge clk);
    check("rst_first_pre", 32'({bus.tx_valid, bus.tx_data}), 32'h155);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset",
          32'({bus.tx_valid, bus.tx_err, bus.busy, bus.frame_done}), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_reset_idle", 32'({bus.tx_valid, bus.busy}), 0);

    rand_tables();
    for (int i = 0; i < 18; i++) pl_mem[i] = 8'(i);
    run_frame(18, -1, 1'b0, 1'b0);
    rand_tables();
    run_frame(5, -1, 1'b0, 1'b0);
    rand_tables();
    run_frame(100, 40, 1'b0, 1'b0);

    reject(0);
    reject(1473);
    reject(2047);

    bus.phy_ready = 1'b0;
    bus.send_len  = 11'd18;
    bus.send_req  = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.send_ack || bus.send_err || bus.tx_valid) cnt++;
    end
    check("phy_gate", 32'(cnt), 0);
    bus.send_req  = 1'b0;
    bus.phy_ready = 1'b1;
    @(negedge clk);

    rand_tables();
    run_frame(30, -1, 1'b0, 1'b1);
    rand_tables();
    run_frame(1, -1, 1'b0, 1'b0);
    rand_tables();
    run_frame(17, -1, 1'b0, 1'b0);
    rand_tables();
    run_frame(19, -1, 1'b0, 1'b0);
    rand_tables();
    run_frame(1472, -1, 1'b0, 1'b0);
    rand_tables();
    run_frame(20, 0, 1'b0, 1'b0);

    repeat (6) begin
      len  = int'($urandom_range(1, 80));
      drop = ($urandom_range(0, 3) == 0) ?
             int'($urandom_range(0, len - 1)) : -1;
      rand_tables();
      run_frame(len, drop, 1'b0, 1'b0);
    end

    rand_tables();
    run_frame(18, -1, 1'b1, 1'b0);
    cnt = 0;
    bad = 0;
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (bus.tx_valid || !bus.busy) bad++;
      if (bus.send_ack) break;
    end
    check("b2b_ack_gap", 32'(cnt), 13);
    check("b2b_quiet", 32'(bad), 0);
    bus.send_req = 1'b0;
    @(negedge clk);
    check("b2b_first_pre", 32'({bus.tx_valid, bus.tx_data}), 32'h155);
    cnt = 0;
    bad = 0;
    while (cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (bus.tx_valid) bad++;
      if (!bus.busy) break;
    end
    check("b2b_frame2_valid", 32'(bad), 71);
    check("b2b_frame2_end", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
